systolic_result_streamer: RTL and testbench

Drains the 4x4 accumulator result matrix produced by the systolic scheduler and serialises it as a requantised, row-major element stream over a valid/ready handshake. It snapshots the full matrix on the scheduler's `computation_done` pulse, so the scheduler can immediately start the next computation. It then emits one saturated fixed-point element per accepted beat. It sits between the systolic compute core and the downstream consumer (writeback buffer or next layer).

---
 rtl/systolic_result_streamer_pkg.sv | 19 +
 rtl/systolic_result_streamer_requant_sat.sv | 43 ++++
 rtl/systolic_result_streamer.sv | 110 +++++++++++
 tb/tb_systolic_result_streamer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_result_streamer_pkg.sv
// Shared constants and types for the systolic result path.
// Matrix geometry, element widths and the streamer state encoding.
package systolic_pkg;

   localparam int N       = 4;
   localparam int ACC_W   = 32;
   localparam int OUT_W   = 16;
   localparam int SHIFT_W = 5;
   localparam int ROW_W   = $clog2(N);
   localparam int IDX_W   = 2 * ROW_W;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   typedef logic [N-1:0][N-1:0][ACC_W-1:0] frame_t;

endpackage

// File: rtl/systolic_result_streamer_requant_sat.sv
// Combinational round-half-up arithmetic right shift followed by
// saturation of an accumulator value into the output element range.
module requant_sat
   import systolic_pkg::*;
(
   input  logic [ACC_W-1:0]   value_i,
   input  logic [SHIFT_W-1:0] shift_i,
   output logic [OUT_W-1:0]   value_o,
   output logic               sat_o
);

   localparam logic signed [ACC_W:0] SAT_MAX =
      {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] rnd;
   logic signed [ACC_W:0] sum;
   logic signed [ACC_W:0] shifted;

   // One guard bit keeps the rounding add from wrapping at the positive limit;
   // with shift 0 the rounding term is zero so the same path passes v through.
   always_comb begin
      ext = {value_i[ACC_W-1], value_i};
      rnd = '0;
      if (shift_i != '0) begin
         rnd = (ACC_W+1)'(1) << (shift_i - SHIFT_W'(1));
      end
      sum     = ext + rnd;
      shifted = sum >>> shift_i;

      value_o = shifted[OUT_W-1:0];
      sat_o   = 1'b0;
      if (shifted > SAT_MAX) begin
         value_o = SAT_MAX[OUT_W-1:0];
         sat_o   = 1'b1;
      end else if (shifted < SAT_MIN) begin
         value_o = SAT_MIN[OUT_W-1:0];
         sat_o   = 1'b1;
      end
   end

endmodule

// File: rtl/systolic_result_streamer.sv
// Snapshots the NxN accumulator matrix on computation_done and streams it
// row-major as requantised, saturated elements over valid/ready.
//
// state  | meaning
// IDLE   | no frame held, waiting for computation_done
// STREAM | frame held, presenting element idx until the last beat is taken
module systolic_result_streamer
   import systolic_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               computation_done,
   input  frame_t             result_matrix,
   input  logic [SHIFT_W-1:0] shift_amt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_data,
   output logic [ROW_W-1:0]   out_row,
   output logic [ROW_W-1:0]   out_col,
   output logic               out_row_last,
   output logic               out_last,
   output logic               out_sat,
   output logic               busy,
   output logic               overrun
);

   stream_state_t      state_q;
   frame_t             frame_q;
   logic [SHIFT_W-1:0] shift_q;
   logic [IDX_W-1:0]   idx_q;
   logic               overrun_q;

   logic               streaming;
   logic               xfer;
   logic               at_last;
   logic [ROW_W-1:0]   row;
   logic [ROW_W-1:0]   col;
   logic [ACC_W-1:0]   elem;
   logic [OUT_W-1:0]   rq_data;
   logic               rq_sat;

   // N is a power of two, so row/col are just the upper/lower index halves.
   assign streaming = (state_q == STREAM);
   assign row       = idx_q[IDX_W-1:ROW_W];
   assign col       = idx_q[ROW_W-1:0];
   assign at_last   = (idx_q == IDX_W'(N*N - 1));
   assign xfer      = streaming && out_ready;
   assign elem      = frame_q[row][col];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         shift_q   <= '0;
         idx_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (computation_done) begin
                  frame_q <= result_matrix;
                  shift_q <= shift_amt;
                  idx_q   <= '0;
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (xfer && at_last) begin
                  idx_q <= '0;
                  // A pulse on the final accepted beat chains the next frame with no bubble.
                  if (computation_done) begin
                     frame_q <= result_matrix;
                     shift_q <= shift_amt;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  if (xfer) begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
                  if (computation_done) begin
                     overrun_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   requant_sat u_requant_sat (
      .value_i (elem),
      .shift_i (shift_q),
      .value_o (rq_data),
      .sat_o   (rq_sat)
   );

   // Element fields are forced to zero outside a frame so idle outputs match reset.
   assign out_valid    = streaming;
   assign busy         = streaming;
   assign out_row      = row;
   assign out_col      = col;
   assign out_row_last = streaming && (col == ROW_W'(N - 1));
   assign out_last     = streaming && at_last;
   assign out_data     = streaming ? rq_data : '0;
   assign out_sat      = streaming && rq_sat;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Directed bench for systolic_result_streamer: requant vector table plus
// hand-written streaming, backpressure, overrun, chaining and reset sequences.
module tb_systolic_result_streamer;
   import systolic_pkg::*;

   logic               clk;
   logic               rst_n;
   logic               computation_done;
   frame_t             result_matrix;
   logic [SHIFT_W-1:0] shift_amt;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic [ROW_W-1:0]   out_row;
   logic [ROW_W-1:0]   out_col;
   logic               out_row_last;
   logic               out_last;
   logic               out_sat;
   logic               busy;
   logic               overrun;

   int nvec  = 0;
   int nfail = 0;

   frame_t mat;

   typedef struct {
      logic [31:0] v;
      logic [4:0]  sh;
      logic [15:0] d;
      logic        s;
   } rq_vec_t;

   rq_vec_t tv [14];

   systolic_result_streamer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .computation_done (computation_done),
      .result_matrix    (result_matrix),
      .shift_amt        (shift_amt),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .out_row          (out_row),
      .out_col          (out_col),
      .out_row_last     (out_row_last),
      .out_last         (out_last),
      .out_sat          (out_sat),
      .busy             (busy),
      .overrun          (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fill_seq(input int base);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = 32'(base + r*4 + c);
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = v;
   endtask

   // Called at a negedge; returns at the negedge where beat 1 is presented.
   task automatic start_frame(input logic [4:0] sh);
      result_matrix    = mat;
      shift_amt        = sh;
      computation_done = 1'b1;
      @(negedge clk);
      computation_done = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},    32'(out_valid), 32'd0);
      chk({tag, "_data"},     32'(out_data), 32'd0);
      chk({tag, "_row"},      32'(out_row), 32'd0);
      chk({tag, "_col"},      32'(out_col), 32'd0);
      chk({tag, "_row_last"}, 32'(out_row_last), 32'd0);
      chk({tag, "_last"},     32'(out_last), 32'd0);
      chk({tag, "_sat"},      32'(out_sat), 32'd0);
      chk({tag, "_busy"},     32'(busy), 32'd0);
      chk({tag, "_overrun"},  32'(overrun), 32'd0);
   endtask

   initial begin
      #200000;
      nfail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      logic        pat [8];
      int          accepted;
      logic        stalled;
      logic [15:0] held_data;
      logic [1:0]  held_row, held_col;
      logic        held_rl, held_last;

      tv[0]  = '{32'd100,        5'd3,  16'h000D, 1'b0};
      tv[1]  = '{32'hFFFF_FF9C,  5'd3,  16'hFFF4, 1'b0};
      tv[2]  = '{32'h0010_0000,  5'd0,  16'h7FFF, 1'b1};
      tv[3]  = '{32'hFFF0_0000,  5'd0,  16'h8000, 1'b1};
      tv[4]  = '{32'h7FFF_FFFF,  5'd31, 16'h0001, 1'b0};
      tv[5]  = '{32'h8000_0000,  5'd31, 16'hFFFF, 1'b0};
      tv[6]  = '{32'h0000_7FFF,  5'd0,  16'h7FFF, 1'b0};
      tv[7]  = '{32'hFFFF_8000,  5'd0,  16'h8000, 1'b0};
      tv[8]  = '{32'h0000_8000,  5'd0,  16'h7FFF, 1'b1};
      tv[9]  = '{32'd7,          5'd1,  16'h0004, 1'b0};
      tv[10] = '{32'hFFFF_FFFD,  5'd1,  16'hFFFF, 1'b0};
      tv[11] = '{32'h000F_FFFF,  5'd4,  16'h7FFF, 1'b1};
      tv[12] = '{32'h0007_FFF7,  5'd4,  16'h7FFF, 1'b0};
      tv[13] = '{32'd6,          5'd2,  16'h0002, 1'b0};
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

      rst_n            = 1'b0;
      computation_done = 1'b0;
      result_matrix    = '0;
      shift_amt        = '0;
      out_ready        = 1'b0;
      mat              = '0;

      @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Identity frame, ready held high
      fill_seq(1);
      out_ready = 1'b1;
      start_frame(5'd0);
      for (int b = 0; b < 16; b++) begin
         chk("id_data",     32'(out_data), 32'(b + 1));
         chk("id_row",      32'(out_row), 32'(b / 4));
         chk("id_col",      32'(out_col), 32'(b % 4));
         chk("id_row_last", 32'(out_row_last), 32'((b % 4) == 3));
         chk("id_last",     32'(out_last), 32'(b == 15));
         chk("id_valid",    32'(out_valid), 32'd1);
         @(negedge clk);
      end
      chk("id_busy_after",  32'(busy), 32'd0);
      chk("id_valid_after", 32'(out_valid), 32'd0);

      // Backpressure
      fill_seq(1);
      out_ready = 1'b0;
      start_frame(5'd0);
      accepted  = 0;
      stalled   = 1'b0;
      held_data = '0; held_row = '0; held_col = '0; held_rl = 1'b0; held_last = 1'b0;
      for (int cyc = 0; cyc < 100 && accepted < 16; cyc++) begin
         if (stalled) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data",  32'(out_data), 32'(held_data));
            chk("bp_hold_row",   32'(out_row), 32'(held_row));
            chk("bp_hold_col",   32'(out_col), 32'(held_col));
            chk("bp_hold_rl",    32'(out_row_last), 32'(held_rl));
            chk("bp_hold_last",  32'(out_last), 32'(held_last));
         end
         out_ready = pat[cyc % 8];
         if (out_valid && out_ready) begin
            chk("bp_order", 32'(out_data), 32'(accepted + 1));
            accepted++;
            stalled = 1'b0;
         end else begin
            stalled   = out_valid;
            held_data = out_data;
            held_row  = out_row;
            held_col  = out_col;
            held_rl   = out_row_last;
            held_last = out_last;
         end
         @(negedge clk);
      end
      chk("bp_count", 32'(accepted), 32'd16);
      chk("bp_busy_after", 32'(busy), 32'd0);

      // Requantisation / saturation table
      out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         fill_const(tv[i].v);
         start_frame(tv[i].sh);
         chk("rq_data", 32'(out_data), 32'(tv[i].d));
         chk("rq_sat",  32'(out_sat), 32'(tv[i].s));
         repeat (16) @(negedge clk);
         chk("rq_busy_after", 32'(busy), 32'd0);
      end

      // Overrun at beat 5, then chained frame on beat 16
      fill_seq(1);
      start_frame(5'd0);
      for (int b = 0; b < 16; b++) begin
         chk("ov_data",    32'(out_data), 32'(b + 1));
         chk("ov_overrun", 32'(overrun), 32'(b == 5));
         if (b == 4) begin
            fill_const(32'd999);
            result_matrix    = mat;
            computation_done = 1'b1;
         end else if (b == 15) begin
            fill_seq(101);
            result_matrix    = mat;
            computation_done = 1'b1;
         end else begin
            computation_done = 1'b0;
         end
         @(negedge clk);
      end
      computation_done = 1'b0;
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_row0",  32'(out_row), 32'd0);
      chk("b2b_col0",  32'(out_col), 32'd0);
      for (int b = 0; b < 16; b++) begin
         chk("b2b_data",    32'(out_data), 32'(101 + b));
         chk("b2b_overrun", 32'(overrun), 32'd0);
         @(negedge clk);
      end
      chk("b2b_busy_after", 32'(busy), 32'd0);

      // Reset mid-stream after 7 beats
      fill_seq(1);
      start_frame(5'd0);
      repeat (7) @(negedge clk);
      chk("rst_pre_data", 32'(out_data), 32'd8);
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_idle_busy", 32'(busy), 32'd0);
      fill_seq(201);
      start_frame(5'd0);
      for (int b = 0; b < 16; b++) begin
         chk("rst_new_data", 32'(out_data), 32'(201 + b));
         chk("rst_new_row",  32'(out_row), 32'(b / 4));
         chk("rst_new_col",  32'(out_col), 32'(b % 4));
         @(negedge clk);
      end
      chk("rst_new_busy_after", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
